div_arbiter: RTL and testbench

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arbiter_pkg.sv | 14 +
 rtl/div_arbiter_rr_pick.sv | 31 +++
 rtl/div_arbiter.sv | 164 ++++++++++++++++
 tb/tb_div_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_arbiter_pkg.sv
// Shared definitions for the divider arbiter: FSM encoding and default sizing.
package div_arbiter_pkg;

  localparam int NREQ_DEF = 4;
  localparam int TMO_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/div_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after last_grant.
module rr_pick
  import div_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [IDW-1:0]  grant,
  output logic            any_valid
);

  int idx;

  // Scan from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = int'(last_grant) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[IDW'(idx)]) begin
        grant     = IDW'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Arbitrates NREQ requesters onto one external iterative divider, one transaction at a time,
// with a WAIT-state watchdog and a held response channel.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int TMO  = TMO_DEF,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_dividend,
  input  logic [8*NREQ-1:0] req_divisor,
  output logic [NREQ-1:0]   req_ready,
  output logic              div_start,
  output logic [7:0]        div_dividend,
  output logic [7:0]        div_divisor,
  input  logic              div_busy,
  input  logic              div_done,
  input  logic [7:0]        div_quotient,
  input  logic [7:0]        div_remainder,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_quotient,
  output logic [7:0]        rsp_remainder,
  output logic              rsp_dbz,
  output logic              rsp_err
);

  localparam int WDW = $clog2(TMO + 1);

  state_e          state_q, state_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic [NREQ-1:0] req_ready_q, req_ready_d;
  logic            div_start_q, div_start_d;
  logic [7:0]      dividend_q, dividend_d;
  logic [7:0]      divisor_q, divisor_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [7:0]      quot_q, quot_d;
  logic [7:0]      rem_q, rem_d;
  logic            dbz_q, dbz_d;
  logic            err_q, err_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [WDW-1:0]  wd_q, wd_d;

  logic [IDW-1:0]  pick_grant;
  logic            pick_any;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .any_valid  (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    req_ready_d  = '0;
    div_start_d  = 1'b0;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    id_d         = id_q;
    quot_d       = quot_q;
    rem_d        = rem_q;
    dbz_d        = dbz_q;
    err_d        = err_q;
    rsp_valid_d  = rsp_valid_q;
    wd_d         = wd_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          req_ready_d  = NREQ'(1) << pick_grant;
          last_grant_d = pick_grant;
          id_d         = pick_grant;
          dividend_d   = req_dividend[int'(pick_grant)*8 +: 8];
          divisor_d    = req_divisor[int'(pick_grant)*8 +: 8];
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!div_busy) begin
          div_start_d = 1'b1;
          wd_d        = '0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (div_done) begin
          quot_d      = div_quotient;
          rem_d       = div_remainder;
          dbz_d       = (divisor_q == 8'd0);
          err_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (wd_q == WDW'(TMO - 1)) begin
          // Divider never answered: report an error with a zeroed result.
          quot_d      = '0;
          rem_d       = '0;
          dbz_d       = 1'b0;
          err_d       = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      req_ready_q  <= '0;
      div_start_q  <= 1'b0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      id_q         <= '0;
      quot_q       <= '0;
      rem_q        <= '0;
      dbz_q        <= 1'b0;
      err_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      req_ready_q  <= req_ready_d;
      div_start_q  <= div_start_d;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
      id_q         <= id_d;
      quot_q       <= quot_d;
      rem_q        <= rem_d;
      dbz_q        <= dbz_d;
      err_q        <= err_d;
      rsp_valid_q  <= rsp_valid_d;
      wd_q         <= wd_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign div_start     = div_start_q;
  assign div_dividend  = dividend_q;
  assign div_divisor   = divisor_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = id_q;
  assign rsp_quotient  = quot_q;
  assign rsp_remainder = rem_q;
  assign rsp_dbz       = dbz_q;
  assign rsp_err       = err_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural 8-bit iterative divider attached.
module tb_div_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_dividend = '0;
  logic [31:0] req_divisor = '0;
  logic [3:0]  req_ready;
  logic        div_start;
  logic [7:0]  div_dividend, div_divisor;
  logic        div_busy, div_done;
  logic [7:0]  div_quotient, div_remainder;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_quotient, rsp_remainder;
  logic        rsp_dbz, rsp_err;

  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt = 0;
  logic hang = 1'b0;

  always #5 clk = ~clk;

  div_arbiter #(.NREQ(4), .TMO(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .req_ready     (req_ready),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_busy      (div_busy),
    .div_done      (div_done),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_dbz       (rsp_dbz),
    .rsp_err       (rsp_err)
  );

  // Divider model: divide-by-zero answers at once (q=FF, r=dividend), otherwise 7 busy cycles.
  logic [2:0] m_cnt;
  logic [7:0] p_q, p_r;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_busy <= 1'b0; div_done <= 1'b0; m_cnt <= '0;
      div_quotient <= '0; div_remainder <= '0; p_q <= '0; p_r <= '0;
    end else begin
      div_done <= 1'b0;
      if (div_busy) begin
        if (m_cnt == 3'd1) begin
          div_busy <= 1'b0; div_done <= !hang;
          div_quotient <= p_q; div_remainder <= p_r;
        end else begin
          m_cnt <= m_cnt - 3'd1;
        end
      end else if (div_start) begin
        if (div_divisor == 8'd0) begin
          div_done <= !hang; div_quotient <= 8'hFF; div_remainder <= div_dividend;
        end else begin
          div_busy <= 1'b1; m_cnt <= 3'd7;
          p_q <= div_dividend / div_divisor; p_r <= div_dividend % div_divisor;
        end
      end
    end
  end

  always @(posedge clk) if (rst_n && div_start) start_cnt <= start_cnt + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_grant(output logic [3:0] g);
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (req_ready != 4'b0) break;
    end
    g = req_ready;
    n_tests++;
    if (g == 4'b0) begin
      n_fail++;
      $display("FAIL grant_timeout: got no req_ready, expected a grant within 40 cycles");
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      lat++;
      if (rsp_valid) break;
    end
    n_tests++;
    if (!rsp_valid) begin
      n_fail++;
      $display("FAIL rsp_timeout: got no rsp_valid, expected one within 40 cycles");
    end
  endtask

  task automatic accept();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_drop", {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic run_single(input logic [1:0] id, input logic [7:0] dvd, input logic [7:0] dvs,
                            output int lat);
    logic [3:0] g;
    int s0;
    req_dividend[id*8 +: 8] = dvd;
    req_divisor[id*8 +: 8]  = dvs;
    req_valid[id] = 1'b1;
    s0 = start_cnt;
    wait_grant(g);
    req_valid[id] = 1'b0;
    check("grant_onehot", {28'd0, g}, {28'd0, 4'b0001 << id});
    wait_rsp(lat);
    check("start_once", start_cnt - s0, 32'd1);
  endtask

  typedef struct {
    logic [1:0] id;
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    logic [3:0] g;
    int s0;
    logic [7:0] exp_q[4];
    logic [7:0] exp_r[4];

    vecs[0] = '{id: 2'd0, dvd: 8'd25,  dvs: 8'd4,   q: 8'd6,   r: 8'd1,   dbz: 1'b0, lat: 10};
    vecs[1] = '{id: 2'd2, dvd: 8'd123, dvs: 8'd0,   q: 8'hFF,  r: 8'd123, dbz: 1'b1, lat: 3};
    vecs[2] = '{id: 2'd1, dvd: 8'd200, dvs: 8'd7,   q: 8'd28,  r: 8'd4,   dbz: 1'b0, lat: 10};
    vecs[3] = '{id: 2'd3, dvd: 8'd0,   dvs: 8'd5,   q: 8'd0,   r: 8'd0,   dbz: 1'b0, lat: 10};
    vecs[4] = '{id: 2'd3, dvd: 8'd9,   dvs: 8'd0,   q: 8'hFF,  r: 8'd9,   dbz: 1'b1, lat: 3};
    vecs[5] = '{id: 2'd1, dvd: 8'd255, dvs: 8'd255, q: 8'd1,   r: 8'd0,   dbz: 1'b0, lat: 10};
    exp_q = '{8'd10, 8'd127, 8'd0, 8'd66};
    exp_r = '{8'd0,  8'd1,   8'd7, 8'd2};

    // Reset state
    #1;
    check("reset_outputs",
          {req_ready, div_start, div_dividend, div_divisor, rsp_valid, rsp_id, rsp_dbz, rsp_err},
          32'd0);
    check("reset_result", {16'd0, rsp_quotient, rsp_remainder}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_no_pulse", {27'd0, req_ready, div_start}, 32'd0);

    // All four requesters at once: round-robin from requester 0
    req_dividend = {8'd200, 8'd7, 8'd255, 8'd100};
    req_divisor  = {8'd3,   8'd9, 8'd2,   8'd10};
    req_valid    = 4'hF;
    for (int k = 0; k < 4; k++) begin
      s0 = start_cnt;
      wait_grant(g);
      req_valid = req_valid & ~g;
      check("rr_order", {28'd0, g}, {28'd0, 4'b0001 << k});
      wait_rsp(lat);
      check("rr_id", {30'd0, rsp_id}, k);
      check("rr_q", {24'd0, rsp_quotient}, {24'd0, exp_q[k]});
      check("rr_r", {24'd0, rsp_remainder}, {24'd0, exp_r[k]});
      check("rr_start_once", start_cnt - s0, 32'd1);
      $display("[TB] rr txn id=%0d q=%0d r=%0d lat=%0d", rsp_id, rsp_quotient, rsp_remainder, lat);
      accept();
    end

    // Table of single requests
    for (int i = 0; i < 6; i++) begin
      run_single(vecs[i].id, vecs[i].dvd, vecs[i].dvs, lat);
      check("vec_id", {30'd0, rsp_id}, {30'd0, vecs[i].id});
      check("vec_q", {24'd0, rsp_quotient}, {24'd0, vecs[i].q});
      check("vec_r", {24'd0, rsp_remainder}, {24'd0, vecs[i].r});
      check("vec_flags", {30'd0, rsp_dbz, rsp_err}, {30'd0, vecs[i].dbz, 1'b0});
      check("vec_latency", lat, vecs[i].lat);
      $display("[TB] vec %0d txn id=%0d %0d/%0d q=%0d r=%0d dbz=%0d err=%0d lat=%0d", i, rsp_id,
               vecs[i].dvd, vecs[i].dvs, rsp_quotient, rsp_remainder, rsp_dbz, rsp_err, lat);
      accept();
    end

    // Backpressure: payload held, no new grant or start while response is pending
    run_single(2'd1, 8'd60, 8'd7, lat);
    req_dividend[31:24] = 8'd50;
    req_divisor[31:24]  = 8'd5;
    req_valid[3] = 1'b1;
    s0 = start_cnt;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_hold", {13'd0, rsp_valid, rsp_id, rsp_quotient, rsp_remainder},
            {13'd0, 1'b1, 2'd1, 8'd8, 8'd4});
      check("bp_no_grant", {28'd0, req_ready}, 32'd0);
    end
    check("bp_no_start", start_cnt - s0, 32'd0);
    $display("[TB] bp txn id=%0d q=%0d r=%0d", rsp_id, rsp_quotient, rsp_remainder);
    accept();
    wait_grant(g);
    req_valid[3] = 1'b0;
    check("bp_next_grant", {28'd0, g}, 32'h8);
    wait_rsp(lat);
    check("bp_next_payload", {14'd0, rsp_id, rsp_quotient, rsp_remainder}, {14'd0, 2'd3, 8'd10, 8'd0});
    $display("[TB] bp2 txn id=%0d q=%0d r=%0d", rsp_id, rsp_quotient, rsp_remainder);
    accept();

    // Watchdog: divider never signals done
    hang = 1'b1;
    run_single(2'd0, 8'd77, 8'd7, lat);
    check("wd_err", {30'd0, rsp_err, rsp_dbz}, 32'd2);
    check("wd_result", {16'd0, rsp_quotient, rsp_remainder}, 32'd0);
    check("wd_latency", lat, 32'd17);
    $display("[TB] wd txn id=%0d err=%0d lat=%0d", rsp_id, rsp_err, lat);
    accept();
    hang = 1'b0;

    // Reset during WAIT: abandon, then round-robin restarts at requester 0
    req_dividend[7:0] = 8'd30;
    req_divisor[7:0]  = 8'd3;
    req_valid[0] = 1'b1;
    wait_grant(g);
    req_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_outputs",
          {req_ready, div_start, div_dividend, div_divisor, rsp_valid, rsp_id, rsp_dbz, rsp_err},
          32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    s0 = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) s0++;
    end
    check("rst_no_stray_rsp", s0, 32'd0);
    req_dividend = {8'd1, 8'd1, 8'd1, 8'd30};
    req_divisor  = {8'd1, 8'd1, 8'd1, 8'd3};
    req_valid = 4'hF;
    wait_grant(g);
    req_valid = 4'h0;
    check("rst_first_grant", {28'd0, g}, 32'h1);
    wait_rsp(lat);
    check("rst_payload", {14'd0, rsp_id, rsp_quotient, rsp_remainder}, {14'd0, 2'd0, 8'd10, 8'd0});
    $display("[TB] post-reset txn id=%0d q=%0d r=%0d lat=%0d", rsp_id, rsp_quotient, rsp_remainder, lat);
    accept();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
